// File: rtl/m_rst_seq_pkg.sv
// m_rst_seq_pkg: state encoding and default parameters shared by m_rst_seq and its counter.
package m_rst_seq_pkg;
    typedef enum logic [2:0] {
        S_ASSERT   = 3'd0,
        S_HOLD     = 3'd1,
        S_RELEASE  = 3'd2,
        S_RUN      = 3'd3,
        S_SW_DRAIN = 3'd4
    } state_t;
    localparam int N_STAGES_DEF = 4;
    localparam int HOLD_CYC_DEF = 16;
    localparam int GAP_CYC_DEF  = 4;
    localparam int CNT_W_DEF    = 8;
endpackage

// File: rtl/m_rst_seq_cnt.sv
// m_rst_seq_cnt: interval counter with synchronous clear, enable and terminal-match flag.
module m_rst_seq_cnt import m_rst_seq_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CK,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             match
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge CK) begin
        if (clr) cnt <= '0;
        else if (en) cnt <= cnt + CNT_W'(1);
    end
    assign match = cnt == term;
endmodule

// File: rtl/m_rst_seq.sv
// m_rst_seq: staged reset-release controller driving N active-low RN lines from flops.
// M_RST_SEQ_REV_ASSERT_EN: software sequences first drop the stages one by one in reverse order.
module m_rst_seq import m_rst_seq_pkg::*; #(
    parameter int N_STAGES = N_STAGES_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                              CK,
    input  logic                              R,
    input  logic                              sw_rst_req,
    output logic                              sw_rst_ack,
    output logic [N_STAGES-1:0]               rst_n_out,
    output logic                              seq_done,
    output logic [$clog2(N_STAGES+1)-1:0]     stage_idx
);
    localparam int IW = $clog2(N_STAGES+1);
    localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_CYC - 1);
    localparam logic [IW-1:0]    LAST   = IW'(N_STAGES - 1);
    if (N_STAGES < 1 || HOLD_CYC < 1 || GAP_CYC < 1 ||
        64'(HOLD_CYC) >= (64'd1 << CNT_W) || 64'(GAP_CYC) >= (64'd1 << CNT_W)) begin : g_param_err
        $error("m_rst_seq: illegal N_STAGES/HOLD_CYC/GAP_CYC/CNT_W combination");
    end
    state_t state, nstate;
    logic [IW-1:0] nidx;
    logic [N_STAGES-1:0] nrst;
    logic [CNT_W-1:0] term;
    logic armed, pend, narmed, npend, ndone, nack, clr, en, match, fin, acc;
    assign term = state == S_HOLD ? HOLD_T : GAP_T;
    m_rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .CK(CK), .clr(clr), .en(en), .term(term), .match(match)
    );
    always_comb begin
        nstate = state;
        nidx   = stage_idx;
        ndone  = seq_done;
        npend  = pend;
        nack   = 1'b0;
        narmed = armed | ~sw_rst_req;
        en     = state != S_ASSERT && state != S_RUN;
        clr    = R | ~en;
        fin    = 1'b0;
        if (en && match) begin
            clr  = 1'b1;
            nidx = state == S_SW_DRAIN ? stage_idx - 1'b1 : stage_idx + 1'b1;
            fin  = state != S_SW_DRAIN && stage_idx == LAST;
            if (state == S_HOLD) nstate = S_RELEASE;
            if (state == S_SW_DRAIN && nidx == '0) nstate = S_HOLD;
        end
        if (state == S_ASSERT) nstate = S_HOLD;
        if (fin) begin
            nstate = S_RUN;
            ndone  = 1'b1;
            nack   = pend;
            npend  = 1'b0;
        end
        // a request still held when the last stage releases is taken on that same edge
        acc = sw_rst_req && armed && (state == S_RUN || fin);
        if (acc) begin
            clr    = 1'b1;
            narmed = 1'b0;
            npend  = 1'b1;
            nack   = 1'b0;
            ndone  = 1'b0;
`ifdef M_RST_SEQ_REV_ASSERT_EN
            nidx   = nidx - 1'b1;
            nstate = nidx == '0 ? S_HOLD : S_SW_DRAIN;
`else
            nidx   = '0;
            nstate = S_HOLD;
`endif
        end
        for (int i = 0; i < N_STAGES; i++) nrst[i] = i < int'(nidx);
    end
    always_ff @(posedge CK) begin
        if (R) begin
            state      <= S_ASSERT;
            rst_n_out  <= '0;
            stage_idx  <= '0;
            seq_done   <= 1'b0;
            sw_rst_ack <= 1'b0;
            armed      <= 1'b1;
            pend       <= 1'b0;
        end else begin
            state      <= nstate;
            rst_n_out  <= nrst;
            stage_idx  <= nidx;
            seq_done   <= ndone;
            sw_rst_ack <= nack;
            armed      <= narmed;
            pend       <= npend;
        end
    end
endmodule

// File: tb/tb_m_rst_seq.sv
// tb_m_rst_seq: table-driven check of m_rst_seq with defaults and with N_STAGES=HOLD_CYC=GAP_CYC=1.
module tb_m_rst_seq;
    typedef struct {
        bit         b;
        logic       r;
        logic       req;
        int         n;
        logic [3:0] rst;
        logic       done;
        logic       ack;
        logic [2:0] idx;
    } vec_t;
    vec_t v[$];
    logic CK = 1'b0;
    always #5 CK = ~CK;
    logic R_a = 1'b1, req_a = 1'b0, ack_a, done_a;
    logic [3:0] rst_a;
    logic [2:0] idx_a;
    logic R_b = 1'b1, req_b = 1'b0, ack_b, done_b;
    logic [0:0] rst_b, idx_b;
    int applied = 0, miscompares = 0, acks_a = 0, acks_b = 0;
    m_rst_seq u_a (
        .CK(CK), .R(R_a), .sw_rst_req(req_a), .sw_rst_ack(ack_a),
        .rst_n_out(rst_a), .seq_done(done_a), .stage_idx(idx_a)
    );
    m_rst_seq #(.N_STAGES(1), .HOLD_CYC(1), .GAP_CYC(1)) u_b (
        .CK(CK), .R(R_b), .sw_rst_req(req_b), .sw_rst_ack(ack_b),
        .rst_n_out(rst_b), .seq_done(done_b), .stage_idx(idx_b)
    );
    always @(negedge CK) begin
        if (ack_a) acks_a++;
        if (ack_b) acks_b++;
    end
    task automatic add(input bit b, input logic r, input logic req, input int n,
                       input logic [3:0] rst, input logic done, input logic ack, input logic [2:0] idx);
        vec_t t;
        t.b = b; t.r = r; t.req = req; t.n = n;
        t.rst = rst; t.done = done; t.ack = ack; t.idx = idx;
        v.push_back(t);
    endtask
    initial begin
        logic [3:0] g_rst;
        logic [2:0] g_idx;
        logic g_done, g_ack;
        add(0, 1, 0,  3, 4'b0000, 0, 0, 0);
        add(0, 0, 0,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 15, 4'b0000, 0, 0, 0);
        add(0, 0, 0,  1, 4'b0001, 0, 0, 1);
        add(0, 0, 0,  3, 4'b0001, 0, 0, 1);
        add(0, 0, 0,  1, 4'b0011, 0, 0, 2);
        add(0, 0, 0,  4, 4'b0111, 0, 0, 3);
        add(0, 0, 0,  3, 4'b0111, 0, 0, 3);
        add(0, 0, 0,  1, 4'b1111, 1, 0, 4);
        add(0, 0, 0,  5, 4'b1111, 1, 0, 4);
`ifndef M_RST_SEQ_REV_ASSERT_EN
        add(0, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 1, 16, 4'b0001, 0, 0, 1);
        add(0, 0, 1, 11, 4'b0111, 0, 0, 3);
        add(0, 0, 1,  1, 4'b1111, 1, 1, 4);
`else
        add(0, 0, 1,  1, 4'b0111, 0, 0, 3);
        add(0, 0, 1,  4, 4'b0011, 0, 0, 2);
        add(0, 0, 1,  8, 4'b0000, 0, 0, 0);
        add(0, 0, 1, 16, 4'b0001, 0, 0, 1);
        add(0, 0, 1, 11, 4'b0111, 0, 0, 3);
        add(0, 0, 1,  1, 4'b1111, 1, 1, 4);
`endif
        add(0, 0, 1,  1, 4'b1111, 1, 0, 4);
        add(0, 0, 1, 10, 4'b1111, 1, 0, 4);
        add(0, 0, 0,  1, 4'b1111, 1, 0, 4);
`ifndef M_RST_SEQ_REV_ASSERT_EN
        add(0, 0, 1,  1, 4'b0000, 0, 0, 0);
`else
        add(0, 0, 1,  1, 4'b0111, 0, 0, 3);
`endif
        add(0, 1, 0,  2, 4'b0000, 0, 0, 0);
        add(0, 0, 0,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 0,  4, 4'b0000, 0, 0, 0);
        add(0, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 1, 11, 4'b0001, 0, 0, 1);
        add(0, 0, 1, 11, 4'b0111, 0, 0, 3);
`ifndef M_RST_SEQ_REV_ASSERT_EN
        add(0, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 1, 16, 4'b0001, 0, 0, 1);
        add(0, 0, 1, 11, 4'b0111, 0, 0, 3);
        add(0, 0, 1,  1, 4'b1111, 1, 1, 4);
`else
        add(0, 0, 1,  1, 4'b0111, 0, 0, 3);
        add(0, 0, 1, 12, 4'b0000, 0, 0, 0);
        add(0, 0, 1, 16, 4'b0001, 0, 0, 1);
        add(0, 0, 1, 11, 4'b0111, 0, 0, 3);
        add(0, 0, 1,  1, 4'b1111, 1, 1, 4);
`endif
        add(0, 0, 0,  1, 4'b1111, 1, 0, 4);
`ifndef M_RST_SEQ_REV_ASSERT_EN
        add(0, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 21, 4'b0011, 0, 0, 2);
`else
        add(0, 0, 1,  1, 4'b0111, 0, 0, 3);
        add(0, 0, 0, 21, 4'b0000, 0, 0, 0);
`endif
        add(0, 1, 0,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 0,  1, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 16, 4'b0001, 0, 0, 1);
        add(0, 0, 0, 12, 4'b1111, 1, 0, 4);
        add(0, 0, 0,  1, 4'b1111, 1, 0, 4);
        add(1, 1, 0,  2, 4'b0000, 0, 0, 0);
        add(1, 0, 0,  1, 4'b0000, 0, 0, 0);
        add(1, 0, 0,  1, 4'b0001, 1, 0, 1);
        add(1, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(1, 0, 0,  1, 4'b0001, 1, 1, 1);
        add(1, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(1, 0, 0,  1, 4'b0001, 1, 1, 1);
        add(1, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(1, 0, 1,  1, 4'b0001, 1, 1, 1);
        add(1, 0, 1,  1, 4'b0001, 1, 0, 1);
        add(1, 0, 0,  1, 4'b0001, 1, 0, 1);
        add(1, 0, 1,  1, 4'b0000, 0, 0, 0);
        add(1, 0, 0,  1, 4'b0001, 1, 1, 1);
        add(1, 0, 0,  3, 4'b0001, 1, 0, 1);
        @(posedge CK);
        #1;
        for (int i = 0; i < v.size(); i++) begin
            if (v[i].b) begin
                R_b = v[i].r;
                req_b = v[i].req;
            end else begin
                R_a = v[i].r;
                req_a = v[i].req;
            end
            repeat (v[i].n) @(posedge CK);
            #1;
            g_rst  = v[i].b ? {3'b000, rst_b} : rst_a;
            g_idx  = v[i].b ? {2'b00, idx_b} : idx_a;
            g_done = v[i].b ? done_b : done_a;
            g_ack  = v[i].b ? ack_b : ack_a;
            applied++;
            if (g_rst !== v[i].rst || g_idx !== v[i].idx || g_done !== v[i].done || g_ack !== v[i].ack) begin
                miscompares++;
                $display("FAIL vec%0d dut%0d: got rst_n_out=%b stage_idx=%0d seq_done=%b ack=%b, want %b %0d %b %b",
                         i, v[i].b, g_rst, g_idx, g_done, g_ack, v[i].rst, v[i].idx, v[i].done, v[i].ack);
            end
        end
        applied++;
        if (acks_a != 2) begin
            miscompares++;
            $display("FAIL ack_count_a: got %0d, want 2", acks_a);
        end
        applied++;
        if (acks_b != 4) begin
            miscompares++;
            $display("FAIL ack_count_b: got %0d, want 4", acks_b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
